// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter among N requesters.
// Latches the winner's byte and parity mode, then runs one enable/ready frame.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N             = 4,
  parameter int ACK_TIMEOUT   = 4,
  parameter int FRAME_TIMEOUT = 16
) (
  input  logic           baud_clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic [8*N-1:0] req_data_i,
  input  logic [1:0]     parity_i,
  output logic [N-1:0]   gnt_o,
  output logic [N-1:0]   done_o,
  output logic           busy_o,
  output logic           err_o,
  output logic [7:0]     tx_data_o,
  output logic [1:0]     tx_parity_o,
  output logic           tx_enable_o,
  input  logic           tx_ready_i
);

  localparam int TMAX = (ACK_TIMEOUT > FRAME_TIMEOUT) ? ACK_TIMEOUT : FRAME_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int LW   = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TIMEOUT - 1);
  localparam logic [LW-1:0] LAST_INIT  = LW'(N - 1);

  // Handshakes: a requester holds req_i (level) until its one-cycle gnt_o pulse;
  // toward uart_tx, tx_enable_o is held while tx_ready_i is high and dropped on
  // the first cycle tx_ready_i is seen low (frame accepted); tx_ready_i rising
  // again marks the end of the frame.
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] owner_q, owner_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    par_q, par_d;
  logic          en_q, en_d;

  logic [LW-1:0] win;
  logic          win_vld;
  logic [LW-1:0] sel;
  logic [7:0]    win_byte;
  logic [N-1:0]  win_onehot;
  logic [N-1:0]  owner_onehot;

  // Search starts just after the last served requester, so it ends up lowest.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sel     = '0;
    for (int i = 1; i <= N; i++) begin
      sel = LW'((int'(last_q) + i) % N);
      if (!win_vld && req_i[sel]) begin
        win_vld = 1'b1;
        win     = sel;
      end
    end
  end

  always_comb begin
    win_byte     = '0;
    win_onehot   = '0;
    owner_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (win == LW'(k)) begin
        win_byte      = req_data_i[8*k +: 8];
        win_onehot[k] = 1'b1;
      end
      if (owner_q == LW'(k)) begin
        owner_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    timer_d = timer_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = err_q;
    data_d  = data_q;
    par_d   = par_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_ready_i && win_vld) begin
          owner_d = win;
          data_d  = win_byte;
          par_d   = parity_i;
          gnt_d   = win_onehot;
          en_d    = 1'b1;
          timer_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = timer_q + 1'b1;
        if (!tx_ready_i) begin
          // Enable must fall before the frame ends or uart_tx sends it twice.
          en_d    = 1'b0;
          timer_d = '0;
          state_d = ST_SEND;
        end else if (timer_q == ACK_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        timer_d = timer_q + 1'b1;
        if (tx_ready_i) begin
          done_d  = owner_onehot;
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else if (timer_q == FRAME_LAST) begin
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_INIT;
      owner_q <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 8'h00;
      par_q   <= 2'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      data_q  <= data_d;
      par_q   <= par_d;
      en_q    <= en_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign tx_data_o   = data_q;
  assign tx_parity_o = par_q;
  assign tx_enable_o = en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: small uart_tx model, frame/done scoreboards, directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int ACK_TO   = 4;
  localparam int FRAME_TO = 16;

  logic           baud_clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [1:0]     parity;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           err;
  logic [7:0]     tx_data;
  logic [1:0]     tx_par;
  logic           tx_en;
  logic           tx_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  int frames_seen = 0;
  int ready_mode = 0;   // 0 normal, 1 ready tied high, 2 frame never completes

  logic [9:0] exp_q[$];
  int         exp_done_q[$];
  logic [9:0] mon_e;
  int         mon_k;

  // uart_tx model: ready low one cycle after reset, 11-cycle frames
  logic m_ready;
  logic m_started;
  logic m_acc;
  int   m_cnt;

  uart_tx_arbiter #(.N(N), .ACK_TIMEOUT(ACK_TO), .FRAME_TIMEOUT(FRAME_TO)) dut (
    .baud_clk    (baud_clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_data_i  (req_data),
    .parity_i    (parity),
    .gnt_o       (gnt),
    .done_o      (done),
    .busy_o      (busy),
    .err_o       (err),
    .tx_data_o   (tx_data),
    .tx_parity_o (tx_par),
    .tx_enable_o (tx_en),
    .tx_ready_i  (tx_ready)
  );

  // clock / reset-independent counters
  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;

  assign tx_ready = (ready_mode == 1) ? 1'b1 : m_ready;

  always @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready   <= 1'b0;
      m_started <= 1'b0;
      m_acc     <= 1'b0;
      m_cnt     <= 0;
    end else begin
      m_acc <= 1'b0;
      if (!m_started) begin
        m_started <= 1'b1;
        m_ready   <= 1'b1;
      end else if (m_cnt == 0) begin
        if (tx_en && ready_mode != 1) begin
          m_acc   <= 1'b1;
          m_ready <= 1'b0;
          m_cnt   <= 11;
        end
      end else if (ready_mode != 2) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_ready <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard monitors
  always @(negedge baud_clk) begin
    if (rst_n) begin
      if (m_acc) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          check("frame_unexp", {22'd0, tx_par, tx_data}, 32'h3ff);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame", {22'd0, tx_par, tx_data}, {22'd0, mon_e});
        end
      end
      if (done != '0) begin
        last_done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          check("done_unexp", 32'(done), 0);
        end else begin
          mon_k = exp_done_q.pop_front();
          check("done_order", 32'(done), 32'(1 << mon_k));
        end
        check("gnt_done_excl", 32'(gnt & done), 0);
      end
      if (gnt != '0) check("gnt_onehot", 32'($countones(gnt)), 1);
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge baud_clk);
  endtask

  task automatic push_frame(input logic [1:0] p, input logic [7:0] d);
    exp_q.push_back({p, d});
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    int n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 64);
    check("gnt_seen", 32'(gnt != '0), 1);
    g = gnt;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (done == '0 && n < 64);
    check("done_seen", 32'(done != '0), 1);
  endtask

  task automatic wait_en_low();
    int n = 0;
    while (tx_en && n < 32) begin
      tick();
      n++;
    end
    check("en_low_seen", 32'(tx_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    int n;
    int f0;
    rst_n = 1'b0; req = '0; req_data = '0; parity = 2'd0; ready_mode = 0;
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_en", 32'(tx_en), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_par", 32'(tx_par), 0);
    rst_n = 1'b1;

    // all requesting: 0,1,2,3,0 with done->gnt on consecutive cycles
    req_data = 32'h13121110; parity = 2'd0;
    for (int k = 0; k < 5; k++) begin
      push_frame(2'd0, 8'h10 + 8'(k % 4));
      exp_done_q.push_back(k % 4);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      check("t2_gnt", 32'(g), 32'(1 << (k % 4)));
      if (k > 0) check("t2_gap", 32'(cyc - last_done_cyc), 1);
      if (k == 4) req = '0;
    end
    wait_done();

    // fairness skip: last served 0, req 1001 -> 3 then 0
    req_data[31:24] = 8'h33; req_data[7:0] = 8'h30; parity = 2'd1;
    push_frame(2'd1, 8'h33); exp_done_q.push_back(3);
    push_frame(2'd1, 8'h30); exp_done_q.push_back(0);
    req = 4'b1001;
    wait_gnt(g);
    check("t3_gnt_first", 32'(g), 32'h8);
    req = 4'b0001;
    wait_gnt(g);
    check("t3_gnt_second", 32'(g), 32'h1);
    req = '0;
    wait_done();

    // single request, requester 2
    f0 = frames_seen;
    req_data[23:16] = 8'hA5; parity = 2'd2;
    push_frame(2'd2, 8'hA5); exp_done_q.push_back(2);
    req = 4'b0100;
    wait_gnt(g);
    check("t1_gnt", 32'(g), 32'h4);
    check("t1_en", 32'(tx_en), 1);
    check("t1_busy", 32'(busy), 1);
    req = '0;
    tick();
    check("t1_gnt_pulse", 32'(gnt), 0);
    check("t1_ready_low", 32'(tx_ready), 0);
    check("t1_en_hold", 32'(tx_en), 1);
    tick();
    check("t1_en_fall", 32'(tx_en), 0);
    wait_done();
    check("t1_data", 32'(tx_data), 32'hA5);
    check("t1_par", 32'(tx_par), 2);
    repeat (15) tick();
    check("t1_one_frame", 32'(frames_seen - f0), 1);
    check("t1_idle", 32'(busy), 0);

    // latched byte and parity survive input changes after grant
    req_data[15:8] = 8'h3C; parity = 2'd2;
    push_frame(2'd2, 8'h3C); exp_done_q.push_back(1);
    req = 4'b0010;
    wait_gnt(g);
    check("t4_gnt", 32'(g), 32'h2);
    req = '0;
    tick();
    parity = 2'd0; req_data[15:8] = 8'hFF;
    wait_done();
    check("t4_data", 32'(tx_data), 32'h3C);
    check("t4_par", 32'(tx_par), 2);

    // issue timeout: ready stuck high
    ready_mode = 1;
    req_data[23:16] = 8'h55; parity = 2'd0;
    req = 4'b0100;
    wait_gnt(g);
    check("t5_gnt", 32'(g), 32'h4);
    req = '0;
    n = 0;
    while (tx_en && n < 20) begin
      n++;
      tick();
    end
    check("t5_en_cycles", 32'(n), ACK_TO);
    check("t5_err", 32'(err), 1);
    check("t5_busy", 32'(busy), 0);
    ready_mode = 0;
    req_data[7:0] = 8'h77;
    push_frame(2'd0, 8'h77); exp_done_q.push_back(0);
    req = 4'b0001;
    wait_gnt(g);
    check("t5_regrant", 32'(g), 32'h1);
    req = '0;
    check("t5_err_sticky", 32'(err), 1);
    wait_done();

    // reset mid-frame
    req_data[15:8] = 8'h5A; parity = 2'd1;
    push_frame(2'd1, 8'h5A);
    req = 4'b0010;
    wait_gnt(g);
    check("t6_gnt", 32'(g), 32'h2);
    req = '0;
    wait_en_low();
    repeat (3) tick();
    check("t6_in_send", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_en", 32'(tx_en), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_gnt", 32'(gnt), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;

    // frame timeout after reset; first grant goes to requester 0
    ready_mode = 2;
    req_data[7:0] = 8'h99; parity = 2'd1;
    push_frame(2'd1, 8'h99);
    req = 4'b0011;
    wait_gnt(g);
    check("t7_gnt_after_rst", 32'(g), 32'h1);
    req = '0;
    wait_en_low();
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("t7_err_cycles", 32'(n), FRAME_TO);
    check("t7_busy", 32'(busy), 0);
    ready_mode = 0;
    repeat (20) tick();

    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("exp_done_empty", 32'(exp_done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
